// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a programmable settle window.
// Latency: accept at edge E -> rspN_valid after edge E+SETTLE; one op per SETTLE+2 cycles at best.
// Backpressure: request ready only in IDLE; response held in RESP until rspN_ready, stalling both requesters.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 3,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_cmd_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    alu_cmd_t         cmd_q, cmd_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;

    logic gnt0, gnt1;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || last_grant_q);
        gnt1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    // Gated by rst_n so no handshake can complete while reset is held.
    assign req0_ready = rst_n && (state_q == IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == IDLE) && gnt1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req0_ready) begin
                    cmd_d        = '{op: req0_op, a: req0_a, b: req0_b};
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = EXEC;
                end else if (req1_valid && req1_ready) begin
                    cmd_d        = '{op: req1_op, a: req1_a, b: req1_b};
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    if (owner_q) begin
                        rsp1_data_d  = alu_result;
                        rsp1_valid_d = 1'b1;
                    end else begin
                        rsp0_data_d  = alu_result;
                        rsp0_valid_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q && rsp1_ready) begin
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (!owner_q && rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign alu_op     = cmd_q.op;
    assign alu_a      = cmd_q.a;
    assign alu_b      = cmd_q.b;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Three arbiter instances (SETTLE 2, 1, 4) sharing one clock and reset, checked against a result scoreboard.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req0_valid[3], req1_valid[3], req0_ready[3], req1_ready[3];
    logic [2:0]   req0_op[3], req1_op[3], alu_op[3];
    logic [W-1:0] req0_a[3], req0_b[3], req1_a[3], req1_b[3];
    logic         rsp0_valid[3], rsp1_valid[3], rsp0_ready[3], rsp1_ready[3];
    logic [W-1:0] rsp0_data[3], rsp1_data[3], alu_a[3], alu_b[3], alu_result[3];
    logic         busy[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_share_arbiter #(.WIDTH(W), .OPW(3), .SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 4))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(req0_valid[g]), .req0_ready(req0_ready[g]), .req0_op(req0_op[g]),
            .req0_a(req0_a[g]), .req0_b(req0_b[g]),
            .req1_valid(req1_valid[g]), .req1_ready(req1_ready[g]), .req1_op(req1_op[g]),
            .req1_a(req1_a[g]), .req1_b(req1_b[g]),
            .rsp0_valid(rsp0_valid[g]), .rsp0_ready(rsp0_ready[g]), .rsp0_data(rsp0_data[g]),
            .rsp1_valid(rsp1_valid[g]), .rsp1_ready(rsp1_ready[g]), .rsp1_data(rsp1_data[g]),
            .alu_op(alu_op[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_result(alu_result[g]),
            .busy(busy[g])
        );
    end

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd4;

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return {{(W-1){1'b0}}, (a < b)};
        endcase
    endfunction

    // Free-running tick; with drift on, the ALU output changes every cycle.
    logic [W-1:0] tick = '0;
    logic         drift;
    always @(posedge clk) tick <= tick + 1;

    always_comb begin
        for (int i = 0; i < 3; i++)
            alu_result[i] = alu_f(alu_op[i], alu_a[i], alu_b[i]) + (drift ? tick : '0);
    end

    typedef struct {
        logic         port;
        int           d;
        logic [W-1:0] data;
        logic [W-1:0] t0;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, acc_cnt = 0;
    logic lg[3], pv0[3], pv1[3];
    logic [3:0] gh = '0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        for (int d = 0; d < 3; d++) begin
            lg[d] = 1'b1; pv0[d] = 1'b0; pv1[d] = 1'b0;
        end
    endtask

    // Grant prediction, scoreboard push on accept, pop/compare on response handshake.
    logic m_e0, m_e1, m_v, m_r, m_pv;
    logic [W-1:0] m_dat;
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_e0 = req0_valid[d] && (!req1_valid[d] || lg[d]);
                m_e1 = req1_valid[d] && (!req0_valid[d] || !lg[d]);
                if (req0_ready[d] || req1_ready[d]) begin
                    chk("grant0", 32'(req0_ready[d]), 32'(m_e0));
                    chk("grant1", 32'(req1_ready[d]), 32'(m_e1));
                    if (m_e0 || m_e1) begin
                        m_e.port = m_e1;
                        m_e.d    = d;
                        m_e.t0   = tick;
                        m_e.data = m_e1 ? alu_f(req1_op[d], req1_a[d], req1_b[d])
                                        : alu_f(req0_op[d], req0_a[d], req0_b[d]);
                        if (drift) m_e.data = m_e.data + tick + W'(settle_of(d));
                        sb.push_back(m_e);
                        lg[d] = m_e1;
                        gh = {gh[2:0], m_e1};
                        acc_cnt++;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    m_v   = p ? rsp1_valid[d] : rsp0_valid[d];
                    m_r   = p ? rsp1_ready[d] : rsp0_ready[d];
                    m_pv  = p ? pv1[d] : pv0[d];
                    m_dat = p ? rsp1_data[d] : rsp0_data[d];
                    if (m_v && !m_pv) begin
                        chk("rsp_has_req", 32'(sb.size()), 1);
                        if (sb.size() != 0) chk("latency", tick - sb[0].t0, 32'(settle_of(d) + 1));
                    end
                    if (m_v && m_r && sb.size() != 0) begin
                        m_e = sb.pop_front();
                        chk("rsp_port", 32'(p), 32'(m_e.port));
                        chk("rsp_dut", 32'(d), 32'(m_e.d));
                        chk("rsp_data", m_dat, m_e.data);
                    end
                    if (p == 1) pv1[d] = m_v; else pv0[d] = m_v;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit p, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        int n = 0;
        if (p) begin req1_op[d] = op; req1_a[d] = a; req1_b[d] = b; req1_valid[d] = 1'b1; end
        else   begin req0_op[d] = op; req0_a[d] = a; req0_b[d] = b; req0_valid[d] = 1'b1; end
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = p ? req1_ready[d] : req0_ready[d];
            cyc();
            n++;
        end
        if (p) req1_valid[d] = 1'b0; else req0_valid[d] = 1'b0;
        chk("accept", 32'(acc), 1);
    endtask

    task automatic wait_rsp(input int d, input bit p);
        int n = 0;
        while (!(p ? rsp1_valid[d] : rsp0_valid[d]) && n < 50) begin cyc(); n++; end
        chk("wait_rsp", 32'(p ? rsp1_valid[d] : rsp0_valid[d]), 1);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((sb.size() != 0 || busy[d]) && n < 200) begin cyc(); n++; end
        chk("wait_idle", 32'(sb.size() == 0 && !busy[d]), 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        model_clear();
        cyc();
        rst_n = 1'b1;
    endtask

    int start;

    initial begin
        rst_n = 1'b0;
        drift = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req0_valid[d] = 0; req1_valid[d] = 0; req0_op[d] = 0; req1_op[d] = 0;
            req0_a[d] = 0; req0_b[d] = 0; req1_a[d] = 0; req1_b[d] = 0;
            rsp0_ready[d] = 0; rsp1_ready[d] = 0;
        end
        model_clear();

        // Reset with both requests active
        req0_valid[0] = 1; req1_valid[0] = 1; req0_a[0] = 32'h55; req1_a[0] = 32'h66;
        #12;
        chk("rst_ready0", 32'(req0_ready[0]), 0);
        chk("rst_ready1", 32'(req1_ready[0]), 0);
        chk("rst_rsp0_valid", 32'(rsp0_valid[0]), 0);
        chk("rst_rsp1_valid", 32'(rsp1_valid[0]), 0);
        chk("rst_alu_a", alu_a[0], 0);
        chk("rst_alu_b", alu_b[0], 0);
        chk("rst_alu_op", 32'(alu_op[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_rsp0_data", rsp0_data[0], 0);
        req0_valid[0] = 0; req1_valid[0] = 0;
        cyc();
        rst_n = 1'b1;

        // Single op with response held
        send(0, 0, OP_ADD, 5, 7);
        wait_rsp(0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_rsp0_valid", 32'(rsp0_valid[0]), 1);
            chk("hold_rsp0_data", rsp0_data[0], 12);
            chk("hold_rsp1_valid", 32'(rsp1_valid[0]), 0);
            chk("hold_busy", 32'(busy[0]), 1);
            cyc();
        end
        rsp0_ready[0] = 1;
        cyc();
        rsp0_ready[0] = 0;
        chk("done_rsp0_valid", 32'(rsp0_valid[0]), 0);
        chk("done_busy", 32'(busy[0]), 0);

        // Tie: both valid continuously
        pulse_reset();
        rsp0_ready[0] = 1; rsp1_ready[0] = 1;
        req0_op[0] = OP_ADD; req0_a[0] = 1; req0_b[0] = 1;
        req1_op[0] = OP_ADD; req1_a[0] = 2; req1_b[0] = 2;
        req0_valid[0] = 1; req1_valid[0] = 1;
        start = acc_cnt;
        for (int n = 0; n < 100 && acc_cnt < start + 4; n++) cyc();
        req0_valid[0] = 0; req1_valid[0] = 0;
        chk("tie_accepts", 32'(acc_cnt - start), 4);
        chk("tie_order", 32'(gh), 32'h5);
        wait_idle(0);
        rsp0_ready[0] = 0; rsp1_ready[0] = 0;

        // Backpressure on rsp1 with req0 waiting
        send(0, 1, OP_ADD, 10, 20);
        req0_op[0] = OP_SUB; req0_a[0] = 100; req0_b[0] = 1; req0_valid[0] = 1;
        wait_rsp(0, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp1_valid", 32'(rsp1_valid[0]), 1);
            chk("bp_rsp1_data", rsp1_data[0], 30);
            chk("bp_ready0", 32'(req0_ready[0]), 0);
            chk("bp_busy", 32'(busy[0]), 1);
            if (i == 0) chk("bp_rsp0_keep", rsp0_data[0], 2);
            cyc();
        end
        rsp1_ready[0] = 1;
        cyc();
        rsp1_ready[0] = 0;
        chk("bp_release_busy", 32'(busy[0]), 0);
        chk("bp_release_ready0", 32'(req0_ready[0]), 1);
        cyc();
        req0_valid[0] = 0;
        rsp0_ready[0] = 1;
        wait_idle(0);
        rsp0_ready[0] = 0;

        // Settle window with a drifting ALU result, SETTLE=1 and SETTLE=4
        drift = 1'b1;
        for (int d = 1; d < 3; d++) begin
            rsp0_ready[d] = 1; rsp1_ready[d] = 1;
            send(d, 0, OP_XOR, 32'h0000F0F0, 32'h00000F0F);
            wait_idle(d);
            send(d, 1, OP_ADD, 100, 200);
            wait_idle(d);
            rsp0_ready[d] = 0; rsp1_ready[d] = 0;
        end
        drift = 1'b0;

        // Async reset mid-EXEC
        rsp0_ready[0] = 1; rsp1_ready[0] = 1;
        send(0, 0, OP_ADD, 3, 4);
        req1_valid[0] = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy[0]), 0);
        chk("arst_alu_a", alu_a[0], 0);
        chk("arst_ready1", 32'(req1_ready[0]), 0);
        chk("arst_rsp0_valid", 32'(rsp0_valid[0]), 0);
        req1_valid[0] = 0;
        model_clear();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("arst_no_stale_rsp", 32'(rsp0_valid[0]), 0);
        end
        send(0, 1, OP_SUB, 9, 1);
        chk("arst_next_op", alu_result[0], 8);
        wait_idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
